// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: counter, position and colour widths plus
// the black colour constant used whenever the pixel is blanked.
package vga_pkg;

  localparam int CNT_W = 11;   // hcount/vcount width
  localparam int POS_W = 12;   // object position width
  localparam int RGB_W = 12;   // 4:4:4 colour width
  localparam int EXT_W = 13;   // compare width wide enough that pos+size never wraps

  localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;

  // Timing bundle carried alongside each pixel through the pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
  } vga_timing_t;

endpackage

// File: rtl/obj_cover.sv
// Single rectangle coverage test: asserts cover_o when the pixel at
// (hcount_i, vcount_i) lies inside the OBJ_W x OBJ_H box whose top-left
// corner is (x_i, y_i). All arithmetic is carried at 13 bits so the far
// edge of an object near the end of the position range cannot wrap.
module obj_cover
  import vga_pkg::*;
#(
  parameter int OBJ_W = 48,
  parameter int OBJ_H = 64
) (
  input  logic [CNT_W-1:0] hcount_i,
  input  logic [CNT_W-1:0] vcount_i,
  input  logic [POS_W-1:0] x_i,
  input  logic [POS_W-1:0] y_i,
  output logic             cover_o
);

  localparam logic [EXT_W-1:0] W_EXT = EXT_W'(OBJ_W);
  localparam logic [EXT_W-1:0] H_EXT = EXT_W'(OBJ_H);

  logic [EXT_W-1:0] h_ext, v_ext, x_ext, y_ext, x_end, y_end;

  assign h_ext = {2'b00, hcount_i};
  assign v_ext = {2'b00, vcount_i};
  assign x_ext = {1'b0, x_i};
  assign y_ext = {1'b0, y_i};
  assign x_end = x_ext + W_EXT;
  assign y_end = y_ext + H_EXT;

  assign cover_o = (h_ext >= x_ext) && (h_ext < x_end) &&
                   (v_ext >= y_ext) && (v_ext < y_end);

endmodule

// File: rtl/object_compositor.sv
// Two-stage object compositor. Stage 1 registers the enable-masked coverage
// vector, the colour of the winning (lowest-index) object, the upstream pixel
// and its timing; stage 2 picks object colour / upstream colour / black.
// Object positions are shadowed and only reloaded on a vblnk rising edge so
// that an object never tears mid-frame.
// Optional feature: define OBJECT_COMPOSITOR_HIT_EN to add the per-object
// overlap accumulator and the frame_hits output.
module object_compositor
  import vga_pkg::*;
#(
  parameter int N_OBJ = 4,
  parameter int OBJ_W = 48,
  parameter int OBJ_H = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT_W-1:0]         hcount_in,
  input  logic [CNT_W-1:0]         vcount_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     hblnk_in,
  input  logic                     vblnk_in,
  input  logic [RGB_W-1:0]         rgb_in,
  input  logic [N_OBJ*POS_W-1:0]   x_pos,
  input  logic [N_OBJ*POS_W-1:0]   y_pos,
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_idx,
  input  logic [RGB_W-1:0]         cfg_color,
  input  logic                     cfg_en,
  output logic [CNT_W-1:0]         hcount_out,
  output logic [CNT_W-1:0]         vcount_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     hblnk_out,
  output logic                     vblnk_out,
  output logic [RGB_W-1:0]         rgb_out
`ifdef OBJECT_COMPOSITOR_HIT_EN
  ,
  output logic [N_OBJ-1:0]         frame_hits
`endif
);

  // Per-object state
  logic [POS_W-1:0] shadow_x_q [N_OBJ];
  logic [POS_W-1:0] shadow_y_q [N_OBJ];
  logic [RGB_W-1:0] colour_q   [N_OBJ];
  logic [N_OBJ-1:0] en_q;
  logic             vblnk_prev_q;

  logic             vblnk_rise;
  logic             cfg_hit;
  logic [N_OBJ-1:0] cover_vec;
  logic [N_OBJ-1:0] cov_masked_d;
  logic [RGB_W-1:0] sel_colour_d;

  // Stage 1
  logic [N_OBJ-1:0] cov1_q;
  logic [RGB_W-1:0] sel1_q;
  logic [RGB_W-1:0] rgb1_q;
  logic [CNT_W-1:0] h1_q, v1_q;
  vga_timing_t      tim1_q;

  // Stage 2 (outputs)
  logic [CNT_W-1:0] h2_q, v2_q;
  vga_timing_t      tim2_q;
  logic [RGB_W-1:0] rgb2_q;
  logic [RGB_W-1:0] rgb2_d;

  assign vblnk_rise = vblnk_in & ~vblnk_prev_q;
  assign cfg_hit    = cfg_we && ({1'b0, cfg_idx} < 4'(N_OBJ));

  // One coverage comparator per object, always against the shadowed corner.
  for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_obj
    obj_cover #(
      .OBJ_W (OBJ_W),
      .OBJ_H (OBJ_H)
    ) u_cover (
      .hcount_i (hcount_in),
      .vcount_i (vcount_in),
      .x_i      (shadow_x_q[gi]),
      .y_i      (shadow_y_q[gi]),
      .cover_o  (cover_vec[gi])
    );
  end

  // Mask by enables and resolve priority: lowest index wins. The winning
  // colour is captured in stage 1 so a colour write only affects pixels that
  // enter stage 1 after it.
  always_comb begin
    cov_masked_d = cover_vec & en_q;
    sel_colour_d = RGB_BLACK;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (cov_masked_d[i]) sel_colour_d = colour_q[i];
    end
  end

  // vblnk edge detector, shadow position reload and configuration writes;
  // a write coinciding with a vblnk rise updates both independently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_prev_q <= 1'b0;
      en_q         <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        shadow_x_q[i] <= '0;
        shadow_y_q[i] <= '0;
        colour_q[i]   <= RGB_BLACK;
      end
    end else begin
      vblnk_prev_q <= vblnk_in;
      for (int i = 0; i < N_OBJ; i++) begin
        if (vblnk_rise) begin
          shadow_x_q[i] <= x_pos[i*POS_W +: POS_W];
          shadow_y_q[i] <= y_pos[i*POS_W +: POS_W];
        end
        if (cfg_hit && (cfg_idx == 3'(i))) begin
          colour_q[i] <= cfg_color;
          en_q[i]     <= cfg_en;
        end
      end
    end
  end

  // Stage 1 register: coverage, winning colour, upstream pixel and timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cov1_q <= '0;
      sel1_q <= RGB_BLACK;
      rgb1_q <= RGB_BLACK;
      h1_q   <= '0;
      v1_q   <= '0;
      tim1_q <= '0;
    end else begin
      cov1_q <= cov_masked_d;
      sel1_q <= sel_colour_d;
      rgb1_q <= rgb_in;
      h1_q   <= hcount_in;
      v1_q   <= vcount_in;
      tim1_q <= '{hsync: hsync_in, vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};
    end
  end

  // Stage 2 colour select: blanking forces black, otherwise object beats background.
  always_comb begin
    rgb2_d = rgb1_q;
    if (tim1_q.hblnk || tim1_q.vblnk) rgb2_d = RGB_BLACK;
    else if (|cov1_q)                 rgb2_d = sel1_q;
  end

  // Stage 2 register driving the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h2_q   <= '0;
      v2_q   <= '0;
      tim2_q <= '0;
      rgb2_q <= RGB_BLACK;
    end else begin
      h2_q   <= h1_q;
      v2_q   <= v1_q;
      tim2_q <= tim1_q;
      rgb2_q <= rgb2_d;
    end
  end

  assign hcount_out = h2_q;
  assign vcount_out = v2_q;
  assign hsync_out  = tim2_q.hsync;
  assign vsync_out  = tim2_q.vsync;
  assign hblnk_out  = tim2_q.hblnk;
  assign vblnk_out  = tim2_q.vblnk;
  assign rgb_out    = rgb2_q;

`ifdef OBJECT_COMPOSITOR_HIT_EN
  logic [N_OBJ-1:0] hit_acc_q;
  logic [N_OBJ-1:0] frame_hits_q;
  logic [N_OBJ-1:0] hit_contrib;
  logic             multi_cover;

  // Two or more bits set <=> clearing the lowest set bit leaves something.
  assign multi_cover = |(cov1_q & (cov1_q - N_OBJ'(1)));
  assign hit_contrib = (multi_cover && !tim1_q.hblnk && !tim1_q.vblnk) ? cov1_q : '0;

  // Accumulate overlaps over a frame; publish and clear on each vblnk rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_acc_q    <= '0;
      frame_hits_q <= '0;
    end else if (vblnk_rise) begin
      frame_hits_q <= hit_acc_q | hit_contrib;
      hit_acc_q    <= '0;
    end else begin
      hit_acc_q    <= hit_acc_q | hit_contrib;
    end
  end

  assign frame_hits = frame_hits_q;
`else
  // Overlap accumulator not built in this configuration.
`endif

endmodule

// File: tb/tb_object_compositor.sv
// Scoreboard bench for object_compositor: each driven pixel pushes its
// hand-computed output (timing delayed, composited colour) into a queue;
// a monitor on the falling edge pops entries as they fall due and compares.
module tb_object_compositor;

  localparam int N_OBJ = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [10:0]          hcount_in, vcount_in;
  logic                 hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0]          rgb_in;
  logic [N_OBJ*12-1:0]  x_pos, y_pos;
  logic                 cfg_we;
  logic [2:0]           cfg_idx;
  logic [11:0]          cfg_color;
  logic                 cfg_en;
  logic [10:0]          hcount_out, vcount_out;
  logic                 hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]          rgb_out;
`ifdef OBJECT_COMPOSITOR_HIT_EN
  logic [N_OBJ-1:0]     frame_hits;
`endif

  object_compositor #(.N_OBJ(N_OBJ), .OBJ_W(48), .OBJ_H(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_color  (cfg_color),
    .cfg_en     (cfg_en),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
`ifdef OBJECT_COMPOSITOR_HIT_EN
    ,
    .frame_hits (frame_hits)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [37:0] exp;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [37:0] act;

  assign act = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [37:0] actual, input logic [37:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Monitor: compare every expectation whose output cycle has arrived.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      $display("pix %-10s h=%0d v=%0d rgb=%h exp_rgb=%h", e.tag,
               hcount_out, vcount_out, rgb_out, e.exp[11:0]);
      check(e.tag, act, e.exp);
    end
  end

  // Apply one pixel for one clock and queue its expected output.
  task automatic drive(input string tag, input int h, input int v,
                       input bit hs, input bit vs, input bit hb, input bit vb,
                       input logic [11:0] rgb, input logic [11:0] exp_rgb);
    exp_t e;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
    e.due = cyc + 2;
    e.exp = {11'(h), 11'(v), hs, vs, hb, vb, exp_rgb};
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One configuration write, issued alongside a blanked pixel.
  task automatic cfg(input int idx, input logic [11:0] col, input bit en);
    cfg_we    = 1'b1;
    cfg_idx   = 3'(idx);
    cfg_color = col;
    cfg_en    = en;
    drive("cfg", 0, 0, 0, 0, 1, 0, 12'hFFF, 12'h000);
    cfg_we    = 1'b0;
  endtask

  task automatic set_pos(input int i, input int x, input int y);
    x_pos[i*12 +: 12] = 12'(x);
    y_pos[i*12 +: 12] = 12'(y);
  endtask

  // Blanked pixel followed by a vblnk rise (shadow reload point).
  task automatic frame_start();
    drive("fs_a", 0, 0,   0, 0, 1, 0, 12'hFFF, 12'h000);
    drive("fs_b", 0, 480, 0, 0, 0, 1, 12'hFFF, 12'h000);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", 38'(sb_q.size()), 38'd0);
  endtask

  initial begin
    rst = 1'b0;
    hcount_in = 11'd123; vcount_in = 11'd45;
    hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
    rgb_in = 12'hFFF;
    x_pos = '0; y_pos = '0;
    cfg_we = 1'b0; cfg_idx = 3'd0; cfg_color = 12'h000; cfg_en = 1'b0;

    // Reset: everything at zero while rst is low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", act, 38'd0);
`ifdef OBJECT_COMPOSITOR_HIT_EN
    check("rst_hits", 38'(frame_hits), 38'd0);
`endif
    rst = 1'b1;

    // No configuration: upstream colour passes with two-cycle latency.
    drive("pass0", 10, 10, 1, 0, 0, 0, 12'hABC, 12'hABC);
    drive("pass1", 11, 10, 0, 1, 0, 0, 12'h123, 12'h123);

    // Single object 48x64 at (100,50): covers h 100..147, v 50..113.
    cfg(0, 12'hF00, 1'b1);
    set_pos(0, 100, 50);
    frame_start();
    drive("s_tl",  100, 50,  0, 0, 0, 0, 12'h0AA, 12'hF00);
    drive("s_br",  147, 113, 0, 0, 0, 0, 12'h0AA, 12'hF00);
    drive("s_rgt", 148, 50,  0, 0, 0, 0, 12'h0AA, 12'h0AA);
    drive("s_bot", 100, 114, 0, 0, 0, 0, 12'h0AA, 12'h0AA);
    drive("s_lft", 99,  50,  0, 0, 0, 0, 12'h0AA, 12'h0AA);

    // Priority: obj0 00F at (200,200), obj1 F00 at (210,210).
    cfg(0, 12'h00F, 1'b1);
    cfg(1, 12'hF00, 1'b1);
    set_pos(0, 200, 200);
    set_pos(1, 210, 210);
    frame_start();
    drive("p_both", 215, 215, 0, 0, 0, 0, 12'h777, 12'h00F);
    drive("p_o0",   205, 205, 0, 0, 0, 0, 12'h777, 12'h00F);
    drive("p_o1",   250, 215, 0, 0, 0, 0, 12'h777, 12'hF00);
    cfg(0, 12'h00F, 1'b0);
    drive("p_dis",  215, 215, 0, 0, 0, 0, 12'h777, 12'hF00);
    drive("p_none", 205, 205, 0, 0, 0, 0, 12'h777, 12'h777);

    // Shadowing: obj0 at (100,280), move x to 300 mid-frame.
    cfg(1, 12'hF00, 1'b0);
    cfg(0, 12'h0F0, 1'b1);
    set_pos(0, 100, 280);
    frame_start();
    drive("sh_a",   100, 290, 0, 0, 0, 0, 12'h321, 12'h0F0);
    set_pos(0, 300, 280);
    drive("sh_old", 100, 300, 0, 0, 0, 0, 12'h321, 12'h0F0);
    drive("sh_new", 300, 300, 0, 0, 0, 0, 12'h321, 12'h321);
    frame_start();
    drive("sh_nw2", 300, 300, 0, 0, 0, 0, 12'h321, 12'h0F0);
    drive("sh_ol2", 100, 300, 0, 0, 0, 0, 12'h321, 12'h321);

    // Blanking forces black even over a covering object.
    drive("bl_h",   300, 300, 1, 0, 1, 0, 12'hFFF, 12'h000);
    drive("bl_act", 310, 300, 0, 0, 0, 0, 12'hFFF, 12'h0F0);
    drive("bl_v",   305, 300, 0, 1, 0, 1, 12'hFFF, 12'h000);

    // Out-of-range writes (idx 7 and 4 with N_OBJ=4) must change nothing.
    cfg(7, 12'h00F, 1'b1);
    cfg(4, 12'h00F, 1'b0);
    drive("oor_o3", 5,   5,   0, 0, 0, 0, 12'h456, 12'h456);
    drive("oor_o0", 300, 300, 0, 0, 0, 0, 12'h456, 12'h0F0);

`ifdef OBJECT_COMPOSITOR_HIT_EN
    // Overlap accumulator: obj0 (100,280) and obj1 (120,290) overlap at (130,300).
    cfg(1, 12'hF00, 1'b1);
    set_pos(0, 100, 280);
    set_pos(1, 120, 290);
    frame_start();
    drive("hit_ov", 130, 300, 0, 0, 0, 0, 12'h111, 12'h0F0);
    frame_start();
    check("hits_overlap", 38'(frame_hits), 38'(4'b0011));
    set_pos(1, 400, 290);
    frame_start();
    drive("hit_ap", 130, 300, 0, 0, 0, 0, 12'h111, 12'h0F0);
    frame_start();
    check("hits_apart", 38'(frame_hits), 38'(4'b0000));
`endif

    drain();

    // Mid-run reset: outputs clear immediately, objects stay disabled after.
    hcount_in = 11'd300; vcount_in = 11'd300;
    hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = 12'hABC;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_async", act, 38'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive("post_rst", 300, 300, 0, 0, 0, 0, 12'h5A5, 12'h5A5);
    drive("post_r2",  100, 300, 0, 0, 0, 0, 12'h5A6, 12'h5A6);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
